// File: rtl/orb_pkg.sv
// Shared types and constants for the ORB orientation block: FSM states,
// default patch radius, moment accumulator width and the octant type.
package orb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_CHECK,
    ST_PATCH,
    ST_BIN,
    ST_EMIT,
    ST_DONE
  } state_t;

  localparam int PATCH_R_DEF = 3;

  // Worst case for R=3, 8-bit pixels: 84 * 255 = 21420, fits signed 16 bits.
  localparam int MOM_W = 16;

  typedef logic [2:0] kp_bin_t;

endpackage

// File: rtl/orb_orient_bin.sv
// Combinational octant classifier: maps the intensity centroid moments
// (m10, m01) to one of eight orientation bins, first matching rule wins.
module orb_orient_bin
  import orb_pkg::*;
(
  input  logic signed [MOM_W-1:0] m10_i,
  input  logic signed [MOM_W-1:0] m01_i,
  output kp_bin_t                 bin_o
);

  // One extra bit so negating the most negative moment cannot wrap.
  logic signed [MOM_W:0] a, b, na, nb;
  logic a_neg, a_zero, a_pos, b_neg, b_zero, b_pos;

  always_comb begin
    a      = (MOM_W+1)'(m10_i);
    b      = (MOM_W+1)'(m01_i);
    na     = -a;
    nb     = -b;
    a_neg  = a[MOM_W];
    b_neg  = b[MOM_W];
    a_zero = (a == '0);
    b_zero = (b == '0);
    a_pos  = !a_neg && !a_zero;
    b_pos  = !b_neg && !b_zero;

    // NOTE: a default before the if-chain keeps this block free of latches.
    bin_o = 3'd7;
    if (a_zero && b_zero)                   bin_o = 3'd0;
    else if (a_pos && !b_neg && (b < a))    bin_o = 3'd0;
    else if (a_pos && b_pos && (b >= a))    bin_o = 3'd1;
    else if (!a_pos && b_pos && (b > na))   bin_o = 3'd2;
    else if (a_neg && !b_neg && (b <= na))  bin_o = 3'd3;
    else if (a_neg && b_neg && (nb < na))   bin_o = 3'd4;
    else if (a_neg && b_neg && (nb >= na))  bin_o = 3'd5;
    else if (!a_neg && b_neg && (nb > a))   bin_o = 3'd6;
  end

endmodule

// File: rtl/orb_orient.sv
// ORB keypoint orientation: raster-scans the FAST corner bitmap, computes
// patch moments around each interior corner and emits an orientation octant.
// Optional kp_count output is enabled by defining ORB_KP_COUNT_EN.
module orb_orient
  import orb_pkg::*;
#(
  parameter int X_MAX       = 400,
  parameter int Y_MAX       = 400,
  parameter int PIXEL_DEPTH = 8,
  parameter int PATCH_R     = PATCH_R_DEF
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       start,
  input  logic [$clog2(X_MAX)-1:0]   max_x,
  input  logic [$clog2(Y_MAX)-1:0]   max_y,
  output logic [$clog2(X_MAX):0]     x_addr_fast,
  output logic [$clog2(Y_MAX):0]     y_addr_fast,
  output logic                       ren_fast,
  input  logic                       rdat_fast,
  output logic [$clog2(X_MAX):0]     x_addr_conv,
  output logic [$clog2(Y_MAX):0]     y_addr_conv,
  output logic                       ren_conv,
  input  logic [PIXEL_DEPTH-1:0]     rdat_conv,
  output logic                       kp_valid,
  input  logic                       kp_ready,
  output logic [$clog2(X_MAX):0]     kp_x,
  output logic [$clog2(Y_MAX):0]     kp_y,
  output logic [2:0]                 kp_bin,
  output logic                       done
`ifdef ORB_KP_COUNT_EN
  ,
  output logic [15:0]                kp_count
`endif
);

  localparam int XW = $clog2(X_MAX) + 1;
  localparam int YW = $clog2(Y_MAX) + 1;
  localparam int OW = $clog2(2 * PATCH_R + 1) + 1;
  localparam logic signed [OW-1:0] OFF_MAX = OW'(PATCH_R);
  localparam logic signed [OW-1:0] OFF_MIN = -OFF_MAX;

  state_t state_q, state_d;
  logic [XW-1:0] x_q, x_d, adv_x;
  logic [YW-1:0] y_q, y_d, adv_y;
  logic signed [OW-1:0] ix_q, ix_d, iy_q, iy_d;
  logic issued_q, issued_d;
  logic rd_vld_q;
  logic signed [OW-1:0] rd_dx_q, rd_dy_q;
  logic signed [MOM_W-1:0] m10_q, m10_d, m01_q, m01_d;
  logic signed [MOM_W-1:0] dx_ext, dy_ext, pix_ext;
  logic [XW-1:0] xf_hold_q, xc_hold_q, xc_addr, kp_x_q;
  logic [YW-1:0] yf_hold_q, yc_hold_q, yc_addr, kp_y_q;
  kp_bin_t kp_bin_q, bin_w;
  logic last_x, last_y, raster_end, in_patch;

  assign last_x     = (x_q == XW'(max_x));
  assign last_y     = (y_q == YW'(max_y));
  assign raster_end = last_x && last_y;
  assign adv_x      = last_x ? '0 : x_q + 1'b1;
  assign adv_y      = last_x ? y_q + 1'b1 : y_q;

  // Compare x+R <= max_x one bit wider so small frames cannot underflow.
  assign in_patch = (x_q >= XW'(PATCH_R)) &&
                    (({1'b0, x_q} + (XW+1)'(PATCH_R)) <= (XW+1)'(max_x)) &&
                    (y_q >= YW'(PATCH_R)) &&
                    (({1'b0, y_q} + (YW+1)'(PATCH_R)) <= (YW+1)'(max_y));

  assign xc_addr = x_q + XW'(ix_q);
  assign yc_addr = y_q + YW'(iy_q);

  assign dx_ext  = MOM_W'(rd_dx_q);
  assign dy_ext  = MOM_W'(rd_dy_q);
  assign pix_ext = MOM_W'(rdat_conv);

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    ix_d     = ix_q;
    iy_d     = iy_q;
    issued_d = issued_q;
    m10_d    = m10_q;
    m01_d    = m01_q;

    if (rd_vld_q) begin
      m10_d = m10_q + dx_ext * pix_ext;
      m01_d = m01_q + dy_ext * pix_ext;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d     = '0;
          y_d     = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN:  state_d = ST_CHECK;
      ST_CHECK: begin
        if (rdat_fast && in_patch) begin
          ix_d     = OFF_MIN;
          iy_d     = OFF_MIN;
          issued_d = 1'b0;
          m10_d    = '0;
          m01_d    = '0;
          state_d  = ST_PATCH;
        end else if (raster_end) begin
          state_d = ST_DONE;
        end else begin
          x_d     = adv_x;
          y_d     = adv_y;
          state_d = ST_SCAN;
        end
      end
      ST_PATCH: begin
        // Once every read is issued, one drain cycle absorbs the last datum.
        if (issued_q) begin
          state_d = ST_BIN;
        end else if (ix_q == OFF_MAX) begin
          ix_d = OFF_MIN;
          if (iy_q == OFF_MAX) issued_d = 1'b1;
          else                 iy_d     = iy_q + 1'b1;
        end else begin
          ix_d = ix_q + 1'b1;
        end
      end
      ST_BIN:   state_d = ST_EMIT;
      ST_EMIT: begin
        if (kp_ready) begin
          if (raster_end) begin
            state_d = ST_DONE;
          end else begin
            x_d     = adv_x;
            y_d     = adv_y;
            state_d = ST_SCAN;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      ix_q      <= '0;
      iy_q      <= '0;
      issued_q  <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_dx_q   <= '0;
      rd_dy_q   <= '0;
      m10_q     <= '0;
      m01_q     <= '0;
      xf_hold_q <= '0;
      yf_hold_q <= '0;
      xc_hold_q <= '0;
      yc_hold_q <= '0;
      kp_x_q    <= '0;
      kp_y_q    <= '0;
      kp_bin_q  <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      ix_q     <= ix_d;
      iy_q     <= iy_d;
      issued_q <= issued_d;
      rd_vld_q <= ren_conv;
      rd_dx_q  <= ix_q;
      rd_dy_q  <= iy_q;
      m10_q    <= m10_d;
      m01_q    <= m01_d;
      if (ren_fast) begin
        xf_hold_q <= x_q;
        yf_hold_q <= y_q;
      end
      if (ren_conv) begin
        xc_hold_q <= xc_addr;
        yc_hold_q <= yc_addr;
      end
      if (state_q == ST_BIN) begin
        kp_x_q   <= x_q;
        kp_y_q   <= y_q;
        kp_bin_q <= bin_w;
      end
    end
  end

  orb_orient_bin u_bin (
    .m10_i (m10_q),
    .m01_i (m01_q),
    .bin_o (bin_w)
  );

  assign ren_fast    = (state_q == ST_SCAN);
  assign ren_conv    = (state_q == ST_PATCH) && !issued_q;
  assign x_addr_fast = ren_fast ? x_q : xf_hold_q;
  assign y_addr_fast = ren_fast ? y_q : yf_hold_q;
  assign x_addr_conv = ren_conv ? xc_addr : xc_hold_q;
  assign y_addr_conv = ren_conv ? yc_addr : yc_hold_q;
  assign kp_valid    = (state_q == ST_EMIT);
  assign kp_x        = kp_x_q;
  assign kp_y        = kp_y_q;
  assign kp_bin      = kp_bin_q;
  assign done        = (state_q == ST_DONE);

`ifdef ORB_KP_COUNT_EN
  logic [15:0] kp_cnt_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      kp_cnt_q <= '0;
    end else if ((state_q == ST_IDLE) && start) begin
      kp_cnt_q <= '0;
    end else if (kp_valid && kp_ready && (kp_cnt_q != 16'hFFFF)) begin
      kp_cnt_q <= kp_cnt_q + 16'd1;
    end
  end

  assign kp_count = kp_cnt_q;
`endif

endmodule
